// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared data width and transmit controller state encoding
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with occupancy count and full/empty flags
// Read data is the combinational head entry; the consumer registers it on pop.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = UART_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wp_q, wp_d;
  logic [ADDR_W-1:0] rp_q, rp_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              push, pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rp_q];

  always_comb begin
    push    = wr_en && !full;
    pop     = rd_en && !empty;
    wp_d    = push ? wp_q + ADDR_W'(1) : wp_q;
    rp_d    = pop  ? rp_q + ADDR_W'(1) : rp_q;
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + (ADDR_W + 1)'(1);
    end else if (pop && !push) begin
      count_d = count_q - (ADDR_W + 1)'(1);
    end
  end

  // Storage carries no reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wp_q] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// rtl/uart_tx_fifo_ctrl.sv - host byte buffer and request pacing for the UART transmitter
// One request per byte; a request unanswered by tx_busy within REQ_TIMEOUT cycles drops the byte.
module uart_tx_fifo_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter int REQ_TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [UART_DATA_W-1:0] wr_data,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  output logic [UART_DATA_W-1:0] tx_data,
  output logic                   tx_transmit,
  input  logic                   tx_busy,
  output logic [ADDR_W:0]        fifo_count,
  output logic                   fifo_empty,
  output logic                   fifo_full,
  output logic                   overflow,
  output logic                   timeout_err
);

  localparam int CNT_W = (REQ_TIMEOUT > 2) ? $clog2(REQ_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REQ_TIMEOUT - 1);

  tx_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [UART_DATA_W-1:0] tx_data_q, tx_data_d;
  logic                   overflow_q, overflow_d;
  logic                   timeout_q, timeout_d;
  logic                   pop;
  logic [UART_DATA_W-1:0] head_data;

  sync_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (UART_DATA_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_valid && wr_ready),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (head_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign wr_ready    = !fifo_full;
  assign tx_data     = tx_data_q;
  assign tx_transmit = (state_q == ST_REQ);
  assign overflow    = overflow_q;
  assign timeout_err = timeout_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tx_data_d  = tx_data_q;
    pop        = 1'b0;
    timeout_d  = 1'b0;
    overflow_d = wr_valid && fifo_full;
    case (state_q)
      ST_IDLE: begin
        // A busy transmitter may be serving another source; hold the head byte.
        if (!fifo_empty && !tx_busy) begin
          pop       = 1'b1;
          tx_data_d = head_data;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        if (tx_busy) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (!tx_busy) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// tb/tb_uart_tx_fifo_ctrl.sv - self-checking bench for uart_tx_fifo_ctrl
module tb_uart_tx_fifo_ctrl;

  localparam int DEPTH       = 16;
  localparam int ADDR_W      = 4;
  localparam int REQ_TIMEOUT = 8;
  localparam int M_IDLE = 0;
  localparam int M_REQ  = 1;
  localparam int M_WAIT = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [7:0]      wr_data = 8'h00;
  logic            wr_valid = 1'b0;
  logic            wr_ready;
  logic [7:0]      tx_data;
  logic            tx_transmit;
  logic            tx_busy = 1'b0;
  logic [ADDR_W:0] fifo_count;
  logic            fifo_empty;
  logic            fifo_full;
  logic            overflow;
  logic            timeout_err;

  uart_tx_fifo_ctrl #(
    .DEPTH       (DEPTH),
    .ADDR_W      (ADDR_W),
    .REQ_TIMEOUT (REQ_TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_data     (wr_data),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .tx_data     (tx_data),
    .tx_transmit (tx_transmit),
    .tx_busy     (tx_busy),
    .fifo_count  (fifo_count),
    .fifo_empty  (fifo_empty),
    .fifo_full   (fifo_full),
    .overflow    (overflow),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  string cur_test = "init";

  // Reference model: queue of bytes held, plus what the controller is doing.
  logic [7:0] mq[$];
  int         phase = M_IDLE;
  int         req_len = 0;
  logic       e_ovf = 1'b0;
  logic       e_to = 1'b0;
  logic [7:0] e_txd = 8'h00;

  // Transmitter model driving tx_busy.
  bit force_busy = 1'b0;
  bit ignore_req = 1'b0;
  bit rand_xmit = 1'b0;
  int rise_delay = 1;
  int busy_len = 3;
  int wait_left = -1;
  int busy_left = 0;

  // Observations of the DUT's request stream.
  logic       prev_tx = 1'b0;
  logic [7:0] sent[$];
  int         n_rise = 0;
  int         n_to = 0;
  int         run_len = 0;
  int         max_run = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s.%s got %0h exp %0h", cur_test, name, got, exp);
    end
  endtask

  task automatic model_edge();
    int pre;
    if (reset) begin
      mq.delete();
      phase   = M_IDLE;
      req_len = 0;
      e_ovf   = 1'b0;
      e_to    = 1'b0;
      e_txd   = 8'h00;
    end else begin
      pre   = mq.size();
      e_ovf = wr_valid && (pre == DEPTH);
      e_to  = 1'b0;
      if (phase == M_IDLE) begin
        if (pre > 0 && !tx_busy) begin
          e_txd   = mq.pop_front();
          phase   = M_REQ;
          req_len = 1;
        end
      end else if (phase == M_REQ) begin
        if (tx_busy) begin
          phase = M_WAIT;
        end else if (req_len == REQ_TIMEOUT) begin
          e_to  = 1'b1;
          phase = M_IDLE;
        end else begin
          req_len++;
        end
      end else begin
        if (!tx_busy) phase = M_IDLE;
      end
      if (wr_valid && pre < DEPTH) mq.push_back(wr_data);
    end
  endtask

  task automatic check_all();
    chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
    chk("fifo_empty", 32'(fifo_empty), 32'(mq.size() == 0));
    chk("fifo_full", 32'(fifo_full), 32'(mq.size() == DEPTH));
    chk("wr_ready", 32'(wr_ready), 32'(mq.size() != DEPTH));
    chk("overflow", 32'(overflow), 32'(e_ovf));
    chk("timeout_err", 32'(timeout_err), 32'(e_to));
    chk("tx_transmit", 32'(tx_transmit), 32'(phase == M_REQ));
    chk("tx_data", 32'(tx_data), 32'(e_txd));
  endtask

  task automatic observe();
    if (tx_transmit && !prev_tx) begin
      n_rise++;
      sent.push_back(tx_data);
    end
    if (timeout_err) n_to++;
    run_len = tx_transmit ? run_len + 1 : 0;
    if (run_len > max_run) max_run = run_len;
    prev_tx = tx_transmit;
  endtask

  task automatic drive_xmit();
    if (force_busy) begin
      tx_busy = 1'b1;
    end else begin
      if (busy_left > 0) begin
        busy_left--;
      end else if (tx_transmit && wait_left < 0 && !ignore_req) begin
        if (rand_xmit) begin
          rise_delay = $urandom_range(0, 11);
          busy_len   = $urandom_range(1, 5);
        end
        wait_left = rise_delay;
      end
      if (wait_left == 0) begin
        busy_left = busy_len;
        wait_left = -1;
      end else if (wait_left > 0) begin
        wait_left--;
      end
      tx_busy = (busy_left > 0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    check_all();
    observe();
    drive_xmit();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    logic [7:0] exp_list[$];
    logic [7:0] b;
    int         base;
    int         to0;
    int         guard;

    // 1: reset held three cycles
    cur_test = "reset";
    reset = 1'b1;
    run(3);
    chk("wr_ready_after_reset", 32'(wr_ready), 32'd1);
    chk("count_after_reset", 32'(fifo_count), 32'd0);
    reset = 1'b0;
    run(2);

    // 2: single byte, busy rises one cycle after request, held 10 cycles
    cur_test = "single";
    rise_delay = 1;
    busy_len   = 10;
    base       = n_rise;
    wr_valid = 1'b1;
    wr_data  = 8'hA5;
    step();
    wr_valid = 1'b0;
    run(25);
    chk("req_count", 32'(n_rise - base), 32'd1);
    chk("tx_data", 32'(tx_data), 32'hA5);
    chk("empty_end", 32'(fifo_empty), 32'd1);

    // 3: fill to full with busy stuck, overflow, then drain in order
    cur_test = "fill";
    force_busy = 1'b1;
    tx_busy    = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'(i);
      step();
    end
    chk("full", 32'(fifo_full), 32'd1);
    chk("wr_ready_full", 32'(wr_ready), 32'd0);
    wr_data = 8'hFF;
    step();
    chk("overflow_pulse", 32'(overflow), 32'd1);
    wr_valid = 1'b0;
    step();
    chk("overflow_clear", 32'(overflow), 32'd0);
    sent.delete();
    force_busy = 1'b0;
    tx_busy    = 1'b0;
    rise_delay = 1;
    busy_len   = 3;
    run(160);
    chk("sent_n", 32'(sent.size()), 32'(DEPTH));
    for (int i = 0; i < sent.size() && i < DEPTH; i++) chk("sent_order", 32'(sent[i]), 32'(i));

    // 4: push and pop on the same edge at occupancy 5
    cur_test = "pushpop";
    exp_list.delete();
    force_busy = 1'b1;
    tx_busy    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      exp_list.push_back(b);
      wr_valid = 1'b1;
      wr_data  = b;
      step();
    end
    chk("count5", 32'(fifo_count), 32'd5);
    b = 8'($urandom);
    exp_list.push_back(b);
    wr_data    = b;
    force_busy = 1'b0;
    tx_busy    = 1'b0;
    sent.delete();
    step();
    chk("count_hold", 32'(fifo_count), 32'd5);
    chk("req_started", 32'(tx_transmit), 32'd1);
    wr_valid = 1'b0;
    busy_len = 2;
    run(70);
    chk("sent_n", 32'(sent.size()), 32'd6);
    for (int i = 0; i < sent.size() && i < 6; i++) chk("order", 32'(sent[i]), 32'(exp_list[i]));

    // 5: transmitter never answers, each request times out
    cur_test = "timeout";
    ignore_req = 1'b1;
    exp_list.delete();
    sent.delete();
    max_run = 0;
    to0     = n_to;
    for (int i = 0; i < 2; i++) begin
      b = 8'($urandom);
      exp_list.push_back(b);
      wr_valid = 1'b1;
      wr_data  = b;
      step();
    end
    wr_valid = 1'b0;
    run(30);
    chk("timeouts", 32'(n_to - to0), 32'd2);
    chk("req_len", 32'(max_run), 32'(REQ_TIMEOUT));
    chk("sent_n", 32'(sent.size()), 32'd2);
    for (int i = 0; i < sent.size() && i < 2; i++) chk("dropped_then_next", 32'(sent[i]), 32'(exp_list[i]));
    ignore_req = 1'b0;

    // 6: reset while waiting on the transmitter with three bytes queued
    cur_test = "midreset";
    rise_delay = 1;
    busy_len   = 20;
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'($urandom);
      step();
    end
    wr_valid = 1'b0;
    guard = 0;
    while (!(tx_busy && !tx_transmit && fifo_count == 3) && guard < 40) begin
      step();
      guard++;
    end
    chk("reached_wait", 32'(guard < 40), 32'd1);
    reset = 1'b1;
    step();
    chk("count_cleared", 32'(fifo_count), 32'd0);
    chk("transmit_low", 32'(tx_transmit), 32'd0);
    reset = 1'b0;
    base  = n_rise;
    run(40);
    chk("no_requests", 32'(n_rise - base), 32'd0);

    // Random traffic, random transmitter timing, occasional stalls and resets
    cur_test = "random";
    rand_xmit = 1'b1;
    for (int i = 0; i < 900; i++) begin
      wr_valid = ($urandom_range(0, 99) < 45);
      wr_data  = 8'($urandom);
      if ($urandom_range(0, 99) < 3) force_busy = !force_busy;
      reset = ($urandom_range(0, 999) < 4);
      step();
    end
    reset      = 1'b0;
    wr_valid   = 1'b0;
    force_busy = 1'b0;
    run(250);
    chk("drained", 32'(fifo_empty), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
